// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier: sign-magnitude operands, one partial product per clock,
// optional early exit once the remaining multiplier bits are all zero.
module shift_add_multiplier #(
  parameter int WIDTH      = 8,
  parameter int EARLY_TERM = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicando,
  input  logic [WIDTH-1:0]     multiplicador,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   producto,
  output logic [1:0]           estado
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CALC   = 2'b01,
    DONE   = 2'b10,
    UNUSED = 2'b11
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [2*WIDTH-1:0]     acc;
  logic [2*WIDTH-1:0]     mag_b;
  logic [2*WIDTH-1:0]     acc_sum;
  logic [WIDTH-1:0]       mag_q;
  logic [WIDTH-1:0]       q_shift;
  logic [WIDTH-1:0]       abs_b;
  logic [WIDTH-1:0]       abs_q;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_inc;
  logic                   neg;
  logic                   mode;
  logic                   last_iter;

  // Negating the most-negative value yields 2^(WIDTH-1), which is exact as an unsigned magnitude.
  always_comb begin
    abs_b     = (signed_mode && multiplicando[WIDTH-1]) ? -multiplicando : multiplicando;
    abs_q     = (signed_mode && multiplicador[WIDTH-1]) ? -multiplicador : multiplicador;
    acc_sum   = mag_q[0] ? (acc + mag_b) : acc;
    q_shift   = mag_q >> 1;
    cnt_inc   = cnt + 1'b1;
    last_iter = (cnt_inc == CW'(WIDTH)) || ((EARLY_TERM != 0) && (q_shift == '0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = start ? CALC : IDLE;
      CALC:    state_next = last_iter ? DONE : CALC;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands are captured only on the accepting edge, so start during CALC/DONE cannot touch them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc      <= '0;
      mag_b    <= '0;
      mag_q    <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      mode     <= 1'b0;
      producto <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode  <= signed_mode;
            mag_b <= {{WIDTH{1'b0}}, abs_b};
            mag_q <= abs_q;
            neg   <= signed_mode & (multiplicando[WIDTH-1] ^ multiplicador[WIDTH-1]);
            acc   <= '0;
            cnt   <= '0;
          end
        end
        CALC: begin
          acc   <= acc_sum;
          mag_b <= mag_b << 1;
          mag_q <= q_shift;
          cnt   <= cnt_inc;
          if (last_iter) begin
            producto <= (mode && neg) ? (~acc_sum + 1'b1) : acc_sum;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state == CALC) || (state == DONE);
  assign done   = (state == DONE);
  assign estado = state;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and randomized checks of shift_add_multiplier: products, cycle counts, done pulse,
// reset abort and start-at-reset-release behaviour.
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst_rnd = 1'b0;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [7:0]  multiplicando = '0;
  logic [7:0]  multiplicador = '0;
  logic        busy_e, done_e, busy_f, done_f;
  logic [15:0] prod_e, prod_f;
  logic [1:0]  st_e, st_f;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.WIDTH(8), .EARLY_TERM(1)) u_early (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .multiplicando(multiplicando), .multiplicador(multiplicador),
    .busy(busy_e), .done(done_e), .producto(prod_e), .estado(st_e)
  );

  shift_add_multiplier #(.WIDTH(8), .EARLY_TERM(0)) u_full (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .multiplicando(multiplicando), .multiplicador(multiplicador),
    .busy(busy_f), .done(done_f), .producto(prod_f), .estado(st_f)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic mode);
    @(negedge clk);
    multiplicando = a;
    multiplicador = b;
    signed_mode   = mode;
    start         = 1'b1;
  endtask

  // Steps through the accept edge, then both DUTs until each has pulsed done once.
  task automatic waitResult(input string tag, input logic [15:0] exp, input int n_e_exp,
                            input int n_f_exp, input bit disturb);
    int n_e = 0;
    int n_f = 0;
    int p_e = 0;
    int p_f = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput($sformatf("%s_calc", tag), {58'd0, busy_e, busy_f, st_e, st_f}, 64'h35);
    for (int c = 1; c <= 40 && (n_e == 0 || n_f == 0); c++) begin
      if (disturb && c == 2) begin
        start = 1'b1;
        multiplicando = 8'h03;
        multiplicador = 8'h01;
        signed_mode = 1'b1;
      end
      if (disturb && c == 5) start = 1'b0;
      @(posedge clk);
      #1;
      if (done_e) begin
        p_e++;
        if (n_e == 0) begin
          n_e = c;
          checkOutput($sformatf("%s_prod_early", tag), 64'(prod_e), 64'(exp));
        end
      end
      if (done_f) begin
        p_f++;
        if (n_f == 0) begin
          n_f = c;
          checkOutput($sformatf("%s_prod_full", tag), 64'(prod_f), 64'(exp));
        end
      end
    end
    @(posedge clk);
    #1;
    if (done_e) p_e++;
    if (done_f) p_f++;
    checkOutput($sformatf("%s_n_early", tag), 64'(n_e), 64'(n_e_exp));
    checkOutput($sformatf("%s_n_full", tag), 64'(n_f), 64'(n_f_exp));
    checkOutput($sformatf("%s_pulses", tag), {32'(p_e), 32'(p_f)}, {32'd1, 32'd1});
    checkOutput($sformatf("%s_idle", tag), {60'd0, busy_e, busy_f, st_e | st_f}, 64'd0);
    checkOutput($sformatf("%s_hold", tag), {32'd0, prod_e, prod_f}, {32'd0, exp, exp});
  endtask

  // Randomized runs at several widths, both EARLY_TERM settings, against a software product.
  for (genvar g = 0; g < 6; g++) begin : rnd
    localparam int W  = (g < 2) ? 4 : ((g < 4) ? 8 : 16);
    localparam int ET = g % 2;
    logic             r_start = 1'b0;
    logic             r_mode = 1'b0;
    logic [W-1:0]     r_a = '0;
    logic [W-1:0]     r_b = '0;
    logic             r_busy, r_done;
    logic [2*W-1:0]   r_prod;
    logic [1:0]       r_st;
    bit               fin = 1'b0;

    shift_add_multiplier #(.WIDTH(W), .EARLY_TERM(ET)) u_dut (
      .clk(clk), .rst(rst_rnd), .start(r_start), .signed_mode(r_mode),
      .multiplicando(r_a), .multiplicador(r_b),
      .busy(r_busy), .done(r_done), .producto(r_prod), .estado(r_st)
    );

    initial begin
      longint       sa, sb;
      logic [63:0]  mask, exp_p;
      logic [W-1:0] mag;
      int           n_exp, n_got;
      mask = (64'd1 << (2 * W)) - 64'd1;
      @(posedge rst_rnd);
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        r_a = W'($urandom());
        r_b = W'($urandom());
        r_mode = 1'($urandom_range(0, 1));
        if (k == 0) r_b = '0;
        if (k == 1) begin
          r_a = '0;
          r_a[W-1] = 1'b1;
          r_b = r_a;
        end
        r_start = 1'b1;
        if (r_mode) begin
          sa = longint'($signed(r_a));
          sb = longint'($signed(r_b));
        end else begin
          sa = longint'(r_a);
          sb = longint'(r_b);
        end
        exp_p = 64'(sa * sb) & mask;
        mag = (r_mode && r_b[W-1]) ? -r_b : r_b;
        n_exp = 1;
        for (int i = 0; i < W; i++) if (mag[i]) n_exp = i + 1;
        if (ET == 0) n_exp = W;
        @(posedge clk);
        #1;
        r_start = 1'b0;
        n_got = 0;
        for (int c = 1; c <= 40 && n_got == 0; c++) begin
          @(posedge clk);
          #1;
          if (r_done) n_got = c;
        end
        checkOutput($sformatf("rnd_w%0d_et%0d_k%0d_prod", W, ET, k), 64'(r_prod), exp_p);
        checkOutput($sformatf("rnd_w%0d_et%0d_k%0d_n", W, ET, k), 64'(n_got), 64'(n_exp));
        @(posedge clk);
        #1;
        checkOutput($sformatf("rnd_w%0d_et%0d_k%0d_pulse", W, ET, k), {62'd0, r_done, r_busy}, 64'd0);
      end
      fin = 1'b1;
    end
  end

  initial begin
    int  rst_dones;
    bit  all_fin;
    #12;
    checkOutput("reset_state", {28'd0, busy_e, done_e, busy_f, done_f, st_e, st_f, prod_e | prod_f},
                64'd0);
    @(negedge clk);
    rst = 1'b1;
    rst_rnd = 1'b1;

    applyStimulus(8'd23, 8'd19, 1'b0);   waitResult("u23x19", 16'h01B5, 5, 8, 1'b0);
    applyStimulus(8'h80, 8'h80, 1'b1);   waitResult("s_min_sq", 16'h4000, 8, 8, 1'b0);
    applyStimulus(8'hFF, 8'h05, 1'b1);   waitResult("s_m1x5", 16'hFFFB, 3, 8, 1'b0);
    applyStimulus(8'h5A, 8'h00, 1'b0);   waitResult("u_x0", 16'h0000, 1, 8, 1'b0);
    applyStimulus(8'h80, 8'h00, 1'b1);   waitResult("s_min_x0", 16'h0000, 1, 8, 1'b0);
    applyStimulus(8'hFF, 8'hFF, 1'b0);   waitResult("u255sq_dist", 16'hFE01, 8, 8, 1'b1);
    applyStimulus(8'h7F, 8'h80, 1'b1);   waitResult("s127xmin", 16'hC080, 8, 8, 1'b0);
    applyStimulus(8'h03, 8'hFA, 1'b1);   waitResult("s3xm6", 16'hFFEE, 3, 8, 1'b0);
    applyStimulus(8'h80, 8'hFF, 1'b0);   waitResult("u128x255", 16'h7F80, 8, 8, 1'b0);

    // Abort 23*19 in its third CALC cycle, then restart with start already high at release.
    applyStimulus(8'd23, 8'd19, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("abort_outputs", {28'd0, busy_e, done_e, busy_f, done_f, st_e, st_f, prod_e | prod_f},
                64'd0);
    rst_dones = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (done_e || done_f || busy_e || busy_f) rst_dones++;
    end
    checkOutput("abort_quiet", 64'(rst_dones), 64'd0);
    @(negedge clk);
    multiplicando = 8'd7;
    multiplicador = 8'd6;
    signed_mode = 1'b0;
    start = 1'b1;
    rst = 1'b1;
    waitResult("after_rst_7x6", 16'h002A, 3, 8, 1'b0);

    all_fin = 1'b0;
    for (int i = 0; i < 20000 && !all_fin; i++) begin
      @(posedge clk);
      all_fin = rnd[0].fin & rnd[1].fin & rnd[2].fin & rnd[3].fin & rnd[4].fin & rnd[5].fin;
    end
    checkOutput("rnd_finished", 64'(all_fin), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
